// File: rtl/enemy_spawner_pkg.sv
// Shared encodings for the enemy spawner: FSM states, enemy type codes,
// LFSR taps and the wave-dependent type mapping.
package enemy_pkg;

  typedef enum logic [2:0] {
    SP_IDLE   = 3'd0,
    SP_WAIT   = 3'd1,
    SP_PICK   = 3'd2,
    SP_ISSUE  = 3'd3,
    SP_SETTLE = 3'd4
  } sp_state_t;

  localparam logic [1:0] TYPE_NONE  = 2'b00;
  localparam logic [1:0] TYPE_BASIC = 2'b01;
  localparam logic [1:0] TYPE_GLASS = 2'b10;
  localparam logic [1:0] TYPE_HEAVY = 2'b11;

  // Taps 16/14/13/11 of a right-shifting Fibonacci LFSR sit at bits 0/2/3/5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Early waves only field basic units; glass appears in wave 1, heavy from wave 2.
  function automatic logic [1:0] map_type(input logic [3:0] wave, input logic [1:0] raw);
    map_type = raw;
    if (raw == TYPE_NONE || wave == 4'd0)
      map_type = TYPE_BASIC;
    else if (wave == 4'd1 && raw == TYPE_HEAVY)
      map_type = TYPE_GLASS;
  endfunction

endpackage

// File: rtl/enemy_spawner_if.sv
// Spawner <-> enemy unit pool bundle, plus read-only debug visibility of the FSM.
// canSpawn is a one-cycle grant strobe with no ready: the selected unit is known
// free (dead=1) when granted, so the grant is always accepted.
interface enemy_spawner_if
  import enemy_pkg::*;
#(
  parameter int NUM_SLOTS = 4
);
  logic                 enable;
  logic                 tick;
  logic [NUM_SLOTS-1:0] dead;
  logic [NUM_SLOTS-1:0] canSpawn;
  logic [1:0]           spawnType;
  logic [3:0]           waveNum;
  logic [2:0]           spawnCount;
  logic                 busy;
  sp_state_t            state;
  logic [7:0]           cd;
  logic [15:0]          lfsr;

  modport master (
    input  enable, tick, dead,
    output canSpawn, spawnType, waveNum, spawnCount, busy, state, cd, lfsr
  );

  modport slave (
    output enable, tick, dead,
    input  canSpawn, spawnType, waveNum, spawnCount, busy, state, cd, lfsr
  );
endinterface

// File: rtl/enemy_spawner_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16/14/13/11), advancing one step per enabled clock.
module spawn_lfsr
  import enemy_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] value
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      value <= SEED;
    else if (en)
      value <= {^(value & LFSR_TAPS), value[15:1]};
  end
endmodule

// File: rtl/enemy_spawner.sv
// Enemy spawner: paces spawns with a tick-driven cooldown, grants the lowest free
// unit slot and picks a wave-dependent enemy type from an LFSR.
module enemy_spawner
  import enemy_pkg::*;
#(
  parameter int          NUM_SLOTS     = 4,
  parameter int          COOLDOWN_BASE = 8,
  parameter int          WAVE_LEN      = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  enemy_spawner_if.master bus
);
  localparam int CD_W = $clog2(COOLDOWN_BASE) + 1;

  sp_state_t            state;
  logic [CD_W-1:0]      cd;
  logic [NUM_SLOTS-1:0] can_spawn;
  logic [1:0]           spawn_type;
  logic [3:0]           wave_num;
  logic [2:0]           spawn_count;
  logic [15:0]          lfsr;
  logic [NUM_SLOTS-1:0] pick;
  logic [2:0]           count_next;
  logic [3:0]           wave_next;

  spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (bus.enable),
    .value (lfsr)
  );

  // Isolates the lowest set bit; zero when no slot is free.
  function automatic logic [NUM_SLOTS-1:0] lowest_free(input logic [NUM_SLOTS-1:0] d);
    lowest_free = d & (~d + 1'b1);
  endfunction

  function automatic logic [CD_W-1:0] cd_load(input logic [3:0] wave);
    case (wave)
      4'd0:    cd_load = CD_W'(COOLDOWN_BASE);
      4'd1:    cd_load = CD_W'(COOLDOWN_BASE >> 1);
      default: cd_load = CD_W'(COOLDOWN_BASE >> 2);
    endcase
  endfunction

  always_comb begin
    pick       = lowest_free(bus.dead);
    count_next = spawn_count + 3'd1;
    wave_next  = wave_num;
    if (spawn_count == 3'(WAVE_LEN - 1)) begin
      count_next = 3'd0;
      wave_next  = (wave_num == 4'd15) ? 4'd15 : wave_num + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SP_IDLE;
      cd          <= '0;
      can_spawn   <= '0;
      spawn_type  <= TYPE_BASIC;
      wave_num    <= 4'd0;
      spawn_count <= 3'd0;
    end else begin
      can_spawn <= '0;
      if (!bus.enable) begin
        // A grant already on the wire still counts toward the wave.
        if (state == SP_ISSUE) begin
          spawn_count <= count_next;
          wave_num    <= wave_next;
        end
        state <= SP_IDLE;
      end else begin
        case (state)
          SP_IDLE: begin
            cd    <= cd_load(wave_num);
            state <= SP_WAIT;
          end
          SP_WAIT: begin
            if (cd == '0)
              state <= SP_PICK;
            else if (bus.tick)
              cd <= cd - 1'b1;
          end
          SP_PICK: begin
            if (pick != '0) begin
              can_spawn  <= pick;
              spawn_type <= map_type(wave_num, lfsr[1:0]);
              state      <= SP_ISSUE;
            end
          end
          SP_ISSUE: begin
            spawn_count <= count_next;
            wave_num    <= wave_next;
            state       <= SP_SETTLE;
          end
          SP_SETTLE: begin
            cd    <= cd_load(wave_num);
            state <= SP_WAIT;
          end
          default: state <= SP_IDLE;
        endcase
      end
    end
  end

  assign bus.canSpawn   = can_spawn;
  assign bus.spawnType  = spawn_type;
  assign bus.waveNum    = wave_num;
  assign bus.spawnCount = spawn_count;
  assign bus.busy       = (state != SP_IDLE);
  assign bus.state      = state;
  assign bus.cd         = 8'(cd);
  assign bus.lfsr       = lfsr;
endmodule
